clock_adjust_ctrl: RTL and testbench
====================================

// Module: clock_adjust_ctrl
// PURPOSE
//   Key-driven set-up controller for the clock/calendar counter. Owns the counter's model[1:0], date_time_ch
//   and adjust_time_num/adjust_date_num inputs. It snapshots the running time/date on entry to adjust mode,
//   then edits one BCD field at a time with range-correct wrap. It returns to run mode on a key press or timeout.
//   Sits between the debounced key pulses and the time counter.
// PARAMETERS
//   CLK_FREQ   50_000_000  clk cycles per second; drives the internal 1 s prescaler for the timeout
//   TIMEOUT_S  10          whole seconds with no key pulse in adjust mode before auto-exit (>=1)
// PORTS
//   clk              in   1   system clock
//   rst_n            in   1   asynchronous active-low reset
//   key_mode         in   1   1-cycle pulse: enter/leave adjust mode
//   key_dt           in   1   1-cycle pulse: toggle time/date view
//   key_sel          in   1   1-cycle pulse: next edit field
//   key_inc          in   1   1-cycle pulse: increment selected field
//   key_dec          in   1   1-cycle pulse: decrement selected field
//   time_num         in   24  running time {h1,h0,m1,m0,s1,s0}, BCD
//   data_num         in   24  running date {y1,y0,mo1,mo0,d1,d0}, BCD
//   model            out  2   2'b00 run, 2'b11 adjust (counter loads adjust value while 11)
//   date_time_ch     out  1   0 = time view/edit, 1 = date view/edit
//   adjust_time_num  out  24  edited time, BCD
//   adjust_date_num  out  24  edited date, BCD
//   edit_field       out  2   0 = hour/year, 1 = min/month, 2 = sec/day (display blink select)
// BEHAVIOUR
//   - Clock, reset and registers
//     - One clock: clk. Reset is asynchronous and active-low: rst_n. Polarity and synchronicity are fixed.
//     - All outputs are registered.
//   - Reset values
//     - model = 00, date_time_ch = 0, edit_field = 0.
//     - adjust_time_num = 24'h000000, adjust_date_num = 24'h200101.
//     - Prescaler and timeout counters = 0.
//   - FSM: RUN (model 00) and ADJ (model 11).
//   - Key priority when pulses coincide: key_mode > key_dt > key_sel > key_inc > key_dec. Only the winner acts.
//   - RUN state
//     - key_mode: state -> ADJ and edit_field <= 0 on the same edge.
//       - date_time_ch = 0: adjust_time_num <= time_num.
//       - date_time_ch = 1: adjust_date_num <= data_num.
//       - model reads 11 from the next cycle. Up to 1 s may be lost at entry; this is accepted.
//     - key_dt: toggles date_time_ch.
//     - key_sel, key_inc, key_dec are ignored.
//   - ADJ state
//     - key_mode: state -> RUN and model <= 00. The counter keeps the last loaded value; no extra commit.
//     - key_dt: toggles date_time_ch, snapshots the newly selected side from time_num/data_num, edit_field <= 0.
//     - key_sel: edit_field 0 -> 1 -> 2 -> 0.
//     - key_inc / key_dec act on the selected 2-digit BCD field of the active side. There is no carry into
//       neighbouring fields.
//   - Field ranges (inc at max -> min; dec at min -> max)
//     - Hour 00-23; min 00-59; sec 00-59.
//     - Year 00-99; month 01-12.
//     - Day 01-max(month), with max = 31/28/31/30/31/30/31/31/30/31/30/31. February is always 28.
//   - Out-of-range field value (invalid digit or above max): inc loads min, dec loads max.
//   - Month edit: day is clamped to the new month's max on the same edge (e.g. 03-31, dec month -> 02-28).
//   - Results are always valid BCD. Arithmetic is per field, 8 bits wide.
//   - Timeout
//     - The 1 s prescaler counts 0..CLK_FREQ-1 and runs only in ADJ.
//     - The seconds counter clears on ADJ entry and on any key pulse in ADJ.
//     - When it reaches TIMEOUT_S, the block exits exactly as for key_mode.
//     - Both counters clear in RUN.
//   - Reset mid-adjust: returns immediately to reset values (RUN).
// TESTING
//   1. Reset -> model = 00, date_time_ch = 0, edit_field = 0, adjust_date_num = 24'h200101.
//   2. RUN, time_num = 24'h235649, key_mode -> next cycle model = 11, adjust_time_num = 24'h235649;
//      key_inc -> 24'h005649; key_dec -> 24'h235649.
//   3. ADJ time, key_sel x2 (edit_field = 2), sec = 59, key_inc -> sec = 00 with min unchanged;
//      key_sel -> edit_field = 0.
//   4. ADJ date 24'h200331, field 1, key_dec -> 24'h200228; field 2, key_inc -> 24'h200201; key_dec -> 24'h200228.
//   5. CLK_FREQ = 10, TIMEOUT_S = 3: enter ADJ, no keys -> model = 00 after 30 cycles;
//      a key_sel at cycle 25 delays the exit to 30 cycles after that pulse.
//   6. ADJ time, key_mode and key_inc in the same cycle -> model = 00 and field unchanged;
//      key_dt in ADJ with data_num = 24'h201228 -> date_time_ch = 1, adjust_date_num = 24'h201228, edit_field = 0.

Source files
------------

// File: rtl/clock_adjust_ctrl.sv
// clock_adjust_ctrl: key-driven set-up controller for the clock/calendar
// counter. Snapshots the running time or date on entry to adjust mode, edits
// one 2-digit BCD field at a time with range-correct wrap, and drops back to
// run mode on a mode key press or after TIMEOUT_S seconds without keys.
module clock_adjust_ctrl #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_dt,
  input  logic        key_sel,
  input  logic        key_inc,
  input  logic        key_dec,
  input  logic [23:0] time_num,
  input  logic [23:0] data_num,
  output logic [1:0]  model,
  output logic        date_time_ch,
  output logic [23:0] adjust_time_num,
  output logic [23:0] adjust_date_num,
  output logic [1:0]  edit_field
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned SW = $clog2(TIMEOUT_S + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [SW-1:0] SECS_LAST = SW'(TIMEOUT_S - 1);

  // The state encoding doubles as the model output seen by the counter.
  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_ADJ = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic          dt_q, dt_d;
  logic [1:0]    field_q, field_d;
  logic [23:0]   time_q, time_d;
  logic [23:0]   date_q, date_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] secs_q, secs_d;

  logic       key_any;
  logic       sec_tick;
  logic       timeout;
  logic [7:0] fld_cur, fld_lo, fld_hi, fld_new, day_max;

  // Both digits must be decimal for a byte to count as a BCD value.
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Increment within [lo, hi]; max or any out-of-range value wraps to lo.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (!bcd_ok(v) || (v < lo) || (v >= hi)) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Decrement within [lo, hi]; min or any out-of-range value wraps to hi.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (!bcd_ok(v) || (v <= lo) || (v > hi)) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Last day of a BCD month; February is fixed at 28, unknown months get 31.
  function automatic logic [7:0] days_in_month(input logic [7:0] mon);
    case (mon)
      8'h02:                      return 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  assign key_any  = key_mode | key_dt | key_sel | key_inc | key_dec;
  assign sec_tick = (presc_q == PRESC_MAX);
  // A key pulse in the same cycle restarts the idle window instead of timing out.
  assign timeout  = (state_q == ST_ADJ) && !key_any && sec_tick && (secs_q == SECS_LAST);

  // Next-state, field editing and idle-timer logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    state_d = state_q;
    dt_d    = dt_q;
    field_d = field_q;
    time_d  = time_q;
    date_d  = date_q;
    presc_d = presc_q;
    secs_d  = secs_q;
    day_max = days_in_month(date_q[15:8]);
    fld_cur = 8'h00;
    fld_lo  = 8'h00;
    fld_hi  = 8'h00;

    case (field_q)
      2'd0:    fld_cur = dt_q ? date_q[23:16] : time_q[23:16];
      2'd1:    fld_cur = dt_q ? date_q[15:8]  : time_q[15:8];
      default: fld_cur = dt_q ? date_q[7:0]   : time_q[7:0];
    endcase

    if (!dt_q) begin
      case (field_q)
        2'd0:    begin fld_lo = 8'h00; fld_hi = 8'h23; end
        default: begin fld_lo = 8'h00; fld_hi = 8'h59; end
      endcase
    end else begin
      case (field_q)
        2'd0:    begin fld_lo = 8'h00; fld_hi = 8'h99;    end
        2'd1:    begin fld_lo = 8'h01; fld_hi = 8'h12;    end
        default: begin fld_lo = 8'h01; fld_hi = day_max;  end
      endcase
    end

    // key_inc outranks key_dec when both pulse together.
    fld_new = key_inc ? bcd_inc(fld_cur, fld_lo, fld_hi) : bcd_dec(fld_cur, fld_lo, fld_hi);

    case (state_q)
      ST_RUN: begin
        if (key_mode) begin
          state_d = ST_ADJ;
          field_d = 2'd0;
          if (dt_q) date_d = data_num;
          else      time_d = time_num;
        end else if (key_dt) begin
          dt_d = ~dt_q;
        end
      end
      ST_ADJ: begin
        if (key_mode || timeout) begin
          state_d = ST_RUN;
        end else if (key_dt) begin
          dt_d    = ~dt_q;
          field_d = 2'd0;
          if (dt_q) time_d = time_num;
          else      date_d = data_num;
        end else if (key_sel) begin
          field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
        end else if (key_inc || key_dec) begin
          if (!dt_q) begin
            case (field_q)
              2'd0:    time_d[23:16] = fld_new;
              2'd1:    time_d[15:8]  = fld_new;
              default: time_d[7:0]   = fld_new;
            endcase
          end else begin
            case (field_q)
              2'd0: date_d[23:16] = fld_new;
              2'd1: begin
                // The day follows the new month down so the date stays legal.
                date_d[15:8] = fld_new;
                if (!bcd_ok(date_q[7:0]) || (date_q[7:0] > days_in_month(fld_new)))
                  date_d[7:0] = days_in_month(fld_new);
              end
              default: date_d[7:0] = fld_new;
            endcase
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Idle timer runs only while adjusting; any key or exit restarts it.
    if ((state_q != ST_ADJ) || key_any || timeout) begin
      presc_d = '0;
      secs_d  = '0;
    end else if (sec_tick) begin
      presc_d = '0;
      secs_d  = secs_q + SW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= ST_RUN;
      dt_q    <= 1'b0;
      field_q <= 2'd0;
      time_q  <= 24'h000000;
      date_q  <= 24'h200101;
      presc_q <= '0;
      secs_q  <= '0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      field_q <= field_d;
      time_q  <= time_d;
      date_q  <= date_d;
      presc_q <= presc_d;
      secs_q  <= secs_d;
    end
  end

  assign model           = state_q;
  assign date_time_ch    = dt_q;
  assign edit_field      = field_q;
  assign adjust_time_num = time_q;
  assign adjust_date_num = date_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// tb_clock_adjust_ctrl: directed scenarios plus random key traffic, checked
// every cycle against an integer-arithmetic model of the set-up controller.
module tb_clock_adjust_ctrl;

  localparam int CF = 10;
  localparam int TS = 3;
  localparam logic [4:0] K_MODE = 5'b10000;
  localparam logic [4:0] K_DT   = 5'b01000;
  localparam logic [4:0] K_SEL  = 5'b00100;
  localparam logic [4:0] K_INC  = 5'b00010;
  localparam logic [4:0] K_DEC  = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_mode = 1'b0, key_dt = 1'b0, key_sel = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic [23:0] time_num = 24'h0, data_num = 24'h0;
  logic [1:0]  model;
  logic        date_time_ch;
  logic [23:0] adjust_time_num, adjust_date_num;
  logic [1:0]  edit_field;

  clock_adjust_ctrl #(.CLK_FREQ(CF), .TIMEOUT_S(TS)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode(key_mode), .key_dt(key_dt), .key_sel(key_sel),
    .key_inc(key_inc), .key_dec(key_dec),
    .time_num(time_num), .data_num(data_num),
    .model(model), .date_time_ch(date_time_ch),
    .adjust_time_num(adjust_time_num), .adjust_date_num(adjust_date_num),
    .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: fields held as BCD bytes, edited via plain integers.
  bit         m_adj, m_dt;
  int         m_field, m_idle;
  logic [7:0] m_t[3];
  logic [7:0] m_d[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bcd(input logic [7:0] b);
    return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
  endfunction

  function automatic int b2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic int month_len(input logic [7:0] mon);
    if (!is_bcd(mon)) return 31;
    case (b2i(mon))
      2:           return 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  function automatic logic [7:0] step_field(input logic [7:0] b, input int lo, input int hi,
                                            input bit up);
    int n;
    if (is_bcd(b) && b2i(b) >= lo && b2i(b) <= hi) begin
      n = b2i(b);
      if (up) n = (n == hi) ? lo : n + 1;
      else    n = (n == lo) ? hi : n - 1;
    end else begin
      n = up ? lo : hi;
    end
    return i2b(n);
  endfunction

  function automatic void model_reset();
    m_adj = 0; m_dt = 0; m_field = 0; m_idle = 0;
    m_t[0] = 8'h00; m_t[1] = 8'h00; m_t[2] = 8'h00;
    m_d[0] = 8'h20; m_d[1] = 8'h01; m_d[2] = 8'h01;
  endfunction

  function automatic void snapshot(input bit date_side, input logic [23:0] t, input logic [23:0] d);
    if (date_side) begin m_d[0] = d[23:16]; m_d[1] = d[15:8]; m_d[2] = d[7:0]; end
    else           begin m_t[0] = t[23:16]; m_t[1] = t[15:8]; m_t[2] = t[7:0]; end
  endfunction

  function automatic void model_step(input logic [4:0] k, input logic [23:0] t, input logic [23:0] d);
    bit any, up;
    int lo, hi;
    any = (k != 5'b0);
    up  = k[1];
    if (!m_adj) begin
      if (k[4]) begin
        m_adj = 1; m_field = 0; m_idle = 0;
        snapshot(m_dt, t, d);
      end else if (k[3]) begin
        m_dt = !m_dt;
      end
      return;
    end
    m_idle = any ? 0 : m_idle + 1;
    if (k[4] || (!any && m_idle == CF * TS)) begin
      m_adj = 0; m_idle = 0;
    end else if (k[3]) begin
      m_dt = !m_dt; m_field = 0;
      snapshot(m_dt, t, d);
    end else if (k[2]) begin
      m_field = (m_field + 1) % 3;
    end else if (k[1] || k[0]) begin
      if (!m_dt) begin
        hi = (m_field == 0) ? 23 : 59;
        m_t[m_field] = step_field(m_t[m_field], 0, hi, up);
      end else if (m_field == 0) begin
        m_d[0] = step_field(m_d[0], 0, 99, up);
      end else if (m_field == 1) begin
        m_d[1] = step_field(m_d[1], 1, 12, up);
        lo = month_len(m_d[1]);
        if (!is_bcd(m_d[2]) || b2i(m_d[2]) > lo) m_d[2] = i2b(lo);
      end else begin
        m_d[2] = step_field(m_d[2], 1, month_len(m_d[1]), up);
      end
    end
  endfunction

  task automatic compare_all();
    check("model", 32'(model), m_adj ? 32'd3 : 32'd0);
    check("date_time_ch", 32'(date_time_ch), 32'(m_dt));
    check("edit_field", 32'(edit_field), 32'(m_field));
    check("adjust_time_num", 32'(adjust_time_num), 32'({m_t[0], m_t[1], m_t[2]}));
    check("adjust_date_num", 32'(adjust_date_num), 32'({m_d[0], m_d[1], m_d[2]}));
  endtask

  // One clock: drive on the falling edge, compare just after the rising edge.
  task automatic tick(input logic [4:0] k, input logic [23:0] t, input logic [23:0] d);
    @(negedge clk);
    {key_mode, key_dt, key_sel, key_inc, key_dec} = k;
    time_num = t;
    data_num = d;
    model_step(k, t, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 9) == 0) return 8'($urandom);
    return i2b(int'($urandom_range(0, 99)));
  endfunction

  function automatic logic [23:0] rand_word();
    return {rand_byte(), rand_byte(), rand_byte()};
  endfunction

  function automatic logic [4:0] rand_keys();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 3)  return K_MODE;
    if (r < 10) return K_DT;
    if (r < 22) return K_SEL;
    if (r < 40) return K_INC;
    if (r < 55) return K_DEC;
    if (r < 60) return 5'($urandom);
    return 5'b0;
  endfunction

  // Run-time bound in case the stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Entry snapshot, hour wrap up and down.
    tick(K_MODE, 24'h235649, 24'h200101);
    check("t2_model", 32'(model), 32'd3);
    check("t2_time", 32'(adjust_time_num), 32'h235649);
    tick(K_INC, 24'h000000, 24'h000000);
    check("t2_inc", 32'(adjust_time_num), 32'h005649);
    tick(K_DEC, 24'h000000, 24'h000000);
    check("t2_dec", 32'(adjust_time_num), 32'h235649);

    // Seconds wrap without carry, field select wrap.
    tick(K_MODE, 24'h0, 24'h0);
    tick(K_MODE, 24'h123459, 24'h0);
    tick(K_SEL, 24'h0, 24'h0);
    tick(K_SEL, 24'h0, 24'h0);
    check("t3_field2", 32'(edit_field), 32'd2);
    tick(K_INC, 24'h0, 24'h0);
    check("t3_sec_wrap", 32'(adjust_time_num), 32'h123400);
    tick(K_SEL, 24'h0, 24'h0);
    check("t3_field0", 32'(edit_field), 32'd0);

    // Month edit clamps the day; day wraps at February's 28.
    tick(K_MODE, 24'h0, 24'h0);
    tick(K_DT, 24'h0, 24'h0);
    check("t4_dt", 32'(date_time_ch), 32'd1);
    tick(K_MODE, 24'h0, 24'h200331);
    check("t4_snap", 32'(adjust_date_num), 32'h200331);
    tick(K_SEL, 24'h0, 24'h0);
    tick(K_DEC, 24'h0, 24'h0);
    check("t4_clamp", 32'(adjust_date_num), 32'h200228);
    tick(K_SEL, 24'h0, 24'h0);
    tick(K_INC, 24'h0, 24'h0);
    check("t4_day_inc", 32'(adjust_date_num), 32'h200201);
    tick(K_DEC, 24'h0, 24'h0);
    check("t4_day_dec", 32'(adjust_date_num), 32'h200228);

    // Key priority and view toggle inside adjust mode.
    tick(K_MODE, 24'h0, 24'h0);
    tick(K_DT, 24'h0, 24'h0);
    tick(K_MODE, 24'h101010, 24'h0);
    tick(K_MODE | K_INC, 24'h0, 24'h0);
    check("t6_exit", 32'(model), 32'd0);
    check("t6_unchanged", 32'(adjust_time_num), 32'h101010);
    tick(K_MODE, 24'h111111, 24'h0);
    tick(K_SEL, 24'h0, 24'h0);
    tick(K_DT, 24'h0, 24'h201228);
    check("t6_dt", 32'(date_time_ch), 32'd1);
    check("t6_date", 32'(adjust_date_num), 32'h201228);
    check("t6_field", 32'(edit_field), 32'd0);

    // Idle timeout after CF*TS cycles, restarted by a key pulse.
    tick(K_MODE, 24'h0, 24'h0);
    tick(K_MODE, 24'h0, 24'h0);
    repeat (CF * TS - 1) tick(5'b0, 24'h0, 24'h0);
    check("t5_before", 32'(model), 32'd3);
    tick(5'b0, 24'h0, 24'h0);
    check("t5_timeout", 32'(model), 32'd0);
    tick(K_MODE, 24'h0, 24'h0);
    repeat (24) tick(5'b0, 24'h0, 24'h0);
    tick(K_SEL, 24'h0, 24'h0);
    repeat (CF * TS - 1) tick(5'b0, 24'h0, 24'h0);
    check("t5_held", 32'(model), 32'd3);
    tick(5'b0, 24'h0, 24'h0);
    check("t5_late_exit", 32'(model), 32'd0);

    // Asynchronous reset in the middle of an edit.
    tick(K_MODE, 24'h0, 24'h150505);
    tick(K_INC, 24'h0, 24'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_model", 32'(model), 32'd0);
    check("rst_date", 32'(adjust_date_num), 32'h200101);
    check("rst_dt", 32'(date_time_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random key traffic with occasional idle stretches.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        for (int j = 0; j < CF * TS + 3; j++) tick(5'b0, rand_word(), rand_word());
      end
      tick(rand_keys(), rand_word(), rand_word());
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
